instr_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder: owns the PC and drives a
//  req/ack instruction-memory port. It presents each fetched 32-bit word to the decoder

---
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a req/ack instruction-memory port, and presents
// fetched words to the decoder over valid/ready, squashing fetches made stale by redirects.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc_out,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_PRESENT = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] pcout_q, pcout_d;
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = valid_q;
      pcout_d = pcout_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            req_d   = 1'b1;
            state_d = S_REQ;
            if (redirect) begin
               pc_d   = redirect_pc;
               addr_d = redirect_pc;
            end else begin
               addr_d = pc_q;
            end
         end
         S_REQ: begin
            if (redirect) begin
               pc_d = redirect_pc;
               // Without an ack the old request must still complete; its data is dropped in DRAIN.
               if (imem_ack) addr_d = redirect_pc;
               else          state_d = S_DRAIN;
            end else if (imem_ack) begin
               instr_d = imem_rdata;
               pcout_d = addr_q;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (redirect) begin
               valid_d = 1'b0;
               pc_d    = redirect_pc;
               req_d   = 1'b1;
               addr_d  = redirect_pc;
               state_d = S_REQ;
            end else if (instr_ready) begin
               cnt_d   = cnt_q + 32'd1;
               pc_d    = pc_q + PC_STEP;
               valid_d = 1'b0;
               req_d   = 1'b1;
               addr_d  = pc_q + PC_STEP;
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            if (redirect) pc_d = redirect_pc;
            if (imem_ack) begin
               addr_d  = redirect ? redirect_pc : pc_q;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
         pcout_q <= RESET_PC;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         pcout_q <= pcout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign pc_out      = pcout_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder with configurable wait states, directed
// scenarios plus random ready/redirect traffic, scoreboard of expected presented PCs.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instruction, pc_out, fetch_count, redirect_pc;
   logic        instr_valid, instr_ready, redirect;

   instr_fetch #(.RESET_PC(32'h0), .PC_STEP(32'd1)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc_out(pc_out), .redirect(redirect), .redirect_pc(redirect_pc), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int mem_wait = 0, exp_gap = 0;
   bit mem_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h1000_0000 + a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory responder: ack after mem_wait cycles (random 0..3 when negative).
   initial begin
      int  wcnt;
      bit  pend;
      wcnt = 0; pend = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk); #1;
         if (!rst_n || !imem_req) begin
            imem_ack = 1'b0; pend = 1'b0;
         end else begin
            if (!pend || imem_ack) begin
               pend = 1'b1;
               wcnt = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
            end else if (wcnt > 0) wcnt--;
            imem_ack = mem_en && (wcnt == 0);
         end
         imem_rdata = imem_ack ? mem(imem_addr) : 32'hDEAD_BEEF;
      end
   end

   // Scoreboard monitor: exp_q holds the PC the decoder should see next.
   logic [31:0] exp_q[$];
   logic [31:0] model_cnt;
   initial begin
      logic [31:0] e, prev_addr;
      bit prev_req, prev_ack;
      int hs_run, last_gap, last_hs;
      prev_req = 0; prev_ack = 0; prev_addr = 0; hs_run = 0; last_gap = 0; last_hs = 0;
      model_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete(); exp_q.push_back(32'h0);
            model_cnt = 0; hs_run = 0; prev_req = 0; prev_ack = 0;
         end else begin
            chk("req_and_valid", 32'(imem_req & instr_valid), 32'd0);
            chk("fetch_count", fetch_count, model_cnt);
            if (prev_req && !prev_ack) begin
               chk("req_hold", 32'(imem_req), 32'd1);
               chk("addr_hold", imem_addr, prev_addr);
            end
            if (redirect) begin
               exp_q.delete(); exp_q.push_back(redirect_pc); hs_run = 0;
            end else if (instr_valid && instr_ready) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL scoreboard_empty: handshake pc_out %h with nothing expected", pc_out);
               end else begin
                  e = exp_q.pop_front();
                  chk("pc_out", pc_out, e);
                  chk("instruction", instruction, mem(e));
                  exp_q.push_back(e + 32'd1);
               end
               model_cnt = model_cnt + 32'd1;
               if (exp_gap != 0 && exp_gap == last_gap && hs_run >= 2)
                  chk("hs_gap", 32'(cyc - last_hs), 32'(exp_gap));
               if (exp_gap == last_gap) hs_run++; else hs_run = 1;
               last_gap = exp_gap; last_hs = cyc;
            end
            prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
         end
      end
   end

   // Driver tasks all run at posedge+2.
   task automatic wait_hs(input int k, input int budget);
      int got = 0, t = 0;
      bit hs;
      while (got < k && t < budget) begin
         hs = instr_valid && instr_ready && !redirect;
         @(posedge clk); #2; t++;
         if (hs) got++;
      end
      chk("hs_timeout", 32'(got), 32'(k));
   endtask

   task automatic do_reset();
      redirect = 1'b0; instr_ready = 1'b1; mem_en = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int t;
      redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
      do_reset();
      // Test 1: reset mid-REQ
      t = 0;
      while (!imem_req && t < 10) begin @(posedge clk); #2; t++; end
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_count", fetch_count, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("rel_req0", 32'(imem_req), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      chk("rel_req1", 32'(imem_req), 32'd1);
      chk("rel_addr", imem_addr, 32'h0);

      // Test 2: zero-wait sequential
      mem_wait = 0; exp_gap = 2; instr_ready = 1'b1; mem_en = 1'b1;
      wait_hs(4, 40);
      chk("count_after_4", fetch_count, 32'd4);
      wait_hs(3, 40);

      // Test 3: three wait states
      mem_wait = 3; exp_gap = 5;
      wait_hs(4, 60);
      exp_gap = 0; mem_wait = 0;

      // Test 4: stall in PRESENT
      instr_ready = 1'b0;
      t = 0;
      while (!instr_valid && t < 20) begin @(posedge clk); #2; t++; end
      for (int i = 0; i < 6; i++) begin
         chk("stall_valid", 32'(instr_valid), 32'd1);
         chk("stall_req", 32'(imem_req), 32'd0);
         chk("stall_pc_out", pc_out, 32'd11);
         chk("stall_instr", instruction, mem(32'd11));
         chk("stall_count", fetch_count, 32'd11);
         @(posedge clk); #2;
      end
      instr_ready = 1'b1;
      wait_hs(1, 20);

      // Test 5: redirect while presenting pc 5
      do_reset(); mem_en = 1'b1; mem_wait = 0;
      t = 0;
      while (t < 40) begin
         instr_ready = !(instr_valid && pc_out == 32'd5);
         if (!instr_ready) break;
         @(posedge clk); #2; t++;
      end
      chk("reach_pc5", pc_out, 32'd5);
      redirect = 1'b1; redirect_pc = 32'h40;
      @(posedge clk); #2;
      redirect = 1'b0;
      chk("rd5_count", fetch_count, 32'd5);
      chk("rd5_valid", 32'(instr_valid), 32'd0);
      chk("rd5_req", 32'(imem_req), 32'd1);
      chk("rd5_addr", imem_addr, 32'h40);
      instr_ready = 1'b1;
      wait_hs(2, 20);

      // Test 6: redirect in REQ with no ack, then drain
      do_reset(); mem_en = 1'b1; mem_wait = 4;
      t = 0;
      while (!(imem_req && imem_addr == 32'd7 && !imem_ack) && t < 100) begin @(posedge clk); #2; t++; end
      chk("reach_addr7", imem_addr, 32'd7);
      redirect = 1'b1; redirect_pc = 32'h20;
      @(posedge clk); #2;
      redirect = 1'b0;
      t = 0;
      while (!imem_ack && t < 20) begin
         chk("drain_addr", imem_addr, 32'd7);
         chk("drain_valid", 32'(instr_valid), 32'd0);
         @(posedge clk); #2; t++;
      end
      chk("drain_ack", 32'(imem_ack), 32'd1);
      @(posedge clk); #2;
      chk("post_drain_req", 32'(imem_req), 32'd1);
      chk("post_drain_addr", imem_addr, 32'h20);
      mem_wait = 0;
      wait_hs(2, 40);

      // Redirect in IDLE straight after reset, then random traffic
      do_reset(); mem_en = 1'b1; mem_wait = -1;
      redirect = 1'b1; redirect_pc = 32'h1234;
      @(posedge clk); #2;
      redirect = 1'b0;
      chk("idle_rd_req", 32'(imem_req), 32'd1);
      chk("idle_rd_addr", imem_addr, 32'h1234);
      for (int i = 0; i < 500; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect = !redirect && ($urandom_range(0, 9) == 0);
         redirect_pc = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE : $urandom;
         @(posedge clk); #2;
      end
      redirect = 1'b0; instr_ready = 1'b1; mem_wait = 0;
      wait_hs(2, 40);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
